// File: rtl/adder_arbiter_2.sv
// Round-robin front end that time-shares one external combinational add/subtract unit
// between two valid/ready requesters, one operation in flight, one response slot each.
module adder_arbiter_2 #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req0_op,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [WIDTH-1:0]     rsp0_result,
    output logic                 rsp0_ovf,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic                 req1_op,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [WIDTH-1:0]     rsp1_result,
    output logic                 rsp1_ovf,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_op,
    input  logic [WIDTH-1:0]     add_result,
    input  logic                 add_ovf,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);

    typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} stage_t;
    typedef enum logic [1:0] {SL_EMPTY = 2'b00, SL_PEND = 2'b01, SL_FULL = 2'b10} slot_t;

    stage_t               stage_r, stage_s;
    slot_t                slot0_r, slot0_s, slot1_r, slot1_s;
    logic                 ptr_r;      // 0: req0 favoured on a tie, 1: req1 favoured
    logic                 owner_r;
    logic [WIDTH-1:0]     op_a_r, op_b_r;
    logic                 op_sub_r;
    logic [WIDTH-1:0]     rsp0_result_r, rsp1_result_r;
    logic                 rsp0_ovf_r, rsp1_ovf_r;
    logic [CNT_WIDTH-1:0] cnt0_r, cnt1_r;
    logic                 elig0_s, elig1_s, grant0_s, grant1_s, done0_s, done1_s;

    function automatic slot_t slot_next(input slot_t cur, input logic acc,
                                        input logic done, input logic take);
        slot_t nxt;
        case (cur)
            SL_EMPTY: nxt = acc  ? SL_PEND  : SL_EMPTY;
            SL_PEND:  nxt = done ? SL_FULL  : SL_PEND;
            SL_FULL:  nxt = take ? SL_EMPTY : SL_FULL;
            default:  nxt = SL_EMPTY;
        endcase
        return nxt;
    endfunction

    // Arbitration: a requester holding an undelivered response cannot compete.
    always_comb begin
        elig0_s  = req0_valid & (slot0_r == SL_EMPTY);
        elig1_s  = req1_valid & (slot1_r == SL_EMPTY);
        grant0_s = (stage_r == ST_IDLE) & elig0_s & (~elig1_s | ~ptr_r);
        grant1_s = (stage_r == ST_IDLE) & elig1_s & (~elig0_s |  ptr_r);
        done0_s  = (stage_r == ST_EXEC) & ~owner_r;
        done1_s  = (stage_r == ST_EXEC) &  owner_r;
    end

    // Stage and response-slot next state.
    always_comb begin
        stage_s = stage_r;
        case (stage_r)
            ST_IDLE: begin
                if (grant0_s | grant1_s) begin
                    stage_s = ST_EXEC;
                end else begin
                    stage_s = ST_IDLE;
                end
            end
            ST_EXEC: stage_s = ST_IDLE;
            default: stage_s = ST_IDLE;
        endcase
        slot0_s = slot_next(slot0_r, grant0_s, done0_s, rsp0_ready);
        slot1_s = slot_next(slot1_r, grant1_s, done1_s, rsp1_ready);
    end

    // State, operand capture, result capture and completion counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stage_r       <= ST_IDLE;
            slot0_r       <= SL_EMPTY;
            slot1_r       <= SL_EMPTY;
            ptr_r         <= 1'b0;
            owner_r       <= 1'b0;
            op_a_r        <= {WIDTH{1'b0}};
            op_b_r        <= {WIDTH{1'b0}};
            op_sub_r      <= 1'b0;
            rsp0_result_r <= {WIDTH{1'b0}};
            rsp1_result_r <= {WIDTH{1'b0}};
            rsp0_ovf_r    <= 1'b0;
            rsp1_ovf_r    <= 1'b0;
            cnt0_r        <= {CNT_WIDTH{1'b0}};
            cnt1_r        <= {CNT_WIDTH{1'b0}};
        end else begin
            stage_r <= stage_s;
            slot0_r <= slot0_s;
            slot1_r <= slot1_s;
            if (grant0_s | grant1_s) begin
                op_a_r   <= grant1_s ? req1_a  : req0_a;
                op_b_r   <= grant1_s ? req1_b  : req0_b;
                op_sub_r <= grant1_s ? req1_op : req0_op;
                owner_r  <= grant1_s;
                ptr_r    <= grant0_s;
            end
            if (done0_s) begin
                rsp0_result_r <= add_result;
                rsp0_ovf_r    <= add_ovf;
                cnt0_r        <= cnt0_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (done1_s) begin
                rsp1_result_r <= add_result;
                rsp1_ovf_r    <= add_ovf;
                cnt1_r        <= cnt1_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign rsp0_valid  = (slot0_r == SL_FULL);
    assign rsp1_valid  = (slot1_r == SL_FULL);
    assign rsp0_result = rsp0_result_r;
    assign rsp1_result = rsp1_result_r;
    assign rsp0_ovf    = rsp0_ovf_r;
    assign rsp1_ovf    = rsp1_ovf_r;
    assign add_a       = op_a_r;
    assign add_b       = op_b_r;
    assign add_op      = op_sub_r;
    assign busy        = (stage_r == ST_EXEC);
    assign cnt0        = cnt0_r;
    assign cnt1        = cnt1_r;

endmodule

// File: tb/tb_adder_arbiter_2.sv
// Directed bench for adder_arbiter_2 with a behavioural 32-bit add/sub unit attached.
module tb_adder_arbiter_2;

    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_ready, req0_op, rsp0_valid, rsp0_ready, rsp0_ovf;
    logic          req1_valid, req1_ready, req1_op, rsp1_valid, rsp1_ready, rsp1_ovf;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [31:0]   add_a, add_b, add_result;
    logic          add_op, add_ovf, busy;
    logic [CW-1:0] cnt0, cnt1;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    typedef struct {
        logic        port;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;
    vec_t vecs[6];
    int   wrap_exp[5];

    always #5 clock = ~clock;

    // Reference adder: two's-complement add/sub with signed overflow.
    assign add_result = add_op ? (add_a - add_b) : (add_a + add_b);
    assign add_ovf    = add_op ? ((add_a[31] != add_b[31]) && (add_result[31] != add_a[31]))
                               : ((add_a[31] == add_b[31]) && (add_result[31] != add_a[31]));

    adder_arbiter_2 #(.WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_ovf(rsp0_ovf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_ovf(rsp1_ovf),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_result(add_result),
        .add_ovf(add_ovf), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 1'b0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
    endtask

    task automatic single_op(input logic p, input logic [31:0] a, input logic [31:0] b,
                             input logic op, input logic [31:0] res, input logic ovf);
        if (p) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; rsp1_ready = 1'b1;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; rsp0_ready = 1'b1;
        end
        #1;
        chk("req_ready", {63'd0, p ? req1_ready : req0_ready}, 64'd1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("busy_exec", {63'd0, busy}, 64'd1);
        chk("add_a", {32'd0, add_a}, {32'd0, a});
        chk("add_b", {32'd0, add_b}, {32'd0, b});
        chk("add_op", {63'd0, add_op}, {63'd0, op});
        cyc();
        if (p) exp_cnt1++; else exp_cnt0++;
        chk("rsp_valid", {63'd0, p ? rsp1_valid : rsp0_valid}, 64'd1);
        chk("rsp_result", {32'd0, p ? rsp1_result : rsp0_result}, {32'd0, res});
        chk("rsp_ovf", {63'd0, p ? rsp1_ovf : rsp0_ovf}, {63'd0, ovf});
        chk("cnt", {62'd0, p ? cnt1 : cnt0}, 64'(p ? exp_cnt1 % 4 : exp_cnt0 % 4));
        cyc();
        chk("rsp_valid_clr", {63'd0, p ? rsp1_valid : rsp0_valid}, 64'd0);
    endtask

    initial begin
        logic [7:0] pat0, pat1;
        vecs[0] = '{port: 1'b0, op: 1'b0, a: 32'd5,          b: 32'd7, res: 32'd12,         ovf: 1'b0};
        vecs[1] = '{port: 1'b1, op: 1'b1, a: 32'h8000_0000,  b: 32'd1, res: 32'h7FFF_FFFF,  ovf: 1'b1};
        vecs[2] = '{port: 1'b0, op: 1'b0, a: 32'h7FFF_FFFF,  b: 32'd1, res: 32'h8000_0000,  ovf: 1'b1};
        vecs[3] = '{port: 1'b1, op: 1'b0, a: 32'hFFFF_FFFF,  b: 32'd1, res: 32'd0,          ovf: 1'b0};
        vecs[4] = '{port: 1'b0, op: 1'b1, a: 32'd3,          b: 32'd5, res: 32'hFFFF_FFFE,  ovf: 1'b0};
        vecs[5] = '{port: 1'b1, op: 1'b1, a: 32'd10,         b: 32'd10, res: 32'd0,         ovf: 1'b0};
        wrap_exp = '{1, 2, 3, 0, 1};

        // Reset state: every output low with no requests pending.
        do_reset();
        chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
        chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        chk("rst_results", {rsp1_result, rsp0_result}, 64'd0);
        chk("rst_ovf", {62'd0, rsp1_ovf, rsp0_ovf}, 64'd0);
        chk("rst_add", {add_a, add_b}, 64'd0);
        chk("rst_add_op_busy", {62'd0, add_op, busy}, 64'd0);
        chk("rst_cnt", {60'd0, cnt1, cnt0}, 64'd0);

        // Both valid continuously: grants alternate 0,1,0,1 two cycles apart.
        pat0 = 8'b0001_0001;
        pat1 = 8'b0100_0100;
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_op = 1'b0; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_op = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_ready0_c%0d", k), {63'd0, req0_ready}, {63'd0, pat0[k]});
            chk($sformatf("rr_ready1_c%0d", k), {63'd0, req1_ready}, {63'd0, pat1[k]});
            if (k == 2) chk("rr_rsp0_result", {32'd0, rsp0_result}, 64'd3);
            if (k == 4) chk("rr_rsp1_result", {32'd0, rsp1_result}, 64'd6);
            if (k == 7) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            cyc();
        end
        cyc();
        chk("rr_cnt0", {62'd0, cnt0}, 64'd2);
        chk("rr_cnt1", {62'd0, cnt1}, 64'd2);
        exp_cnt0 = 2;
        exp_cnt1 = 2;

        // Directed vectors, one requester at a time.
        for (int i = 0; i < 6; i++) begin
            single_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].ovf);
        end

        // Tie-break follows the pointer: last grant was req1, so req0 wins, then req1.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 1'b0; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd3; req1_op = 1'b0; rsp1_ready = 1'b1;
        #1;
        chk("tie_a_ready0", {63'd0, req0_ready}, 64'd1);
        chk("tie_a_ready1", {63'd0, req1_ready}, 64'd0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        exp_cnt0++;
        chk("tie_a_result", {32'd0, rsp0_result}, 64'd2);
        cyc();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("tie_b_ready0", {63'd0, req0_ready}, 64'd0);
        chk("tie_b_ready1", {63'd0, req1_ready}, 64'd1);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        exp_cnt1++;
        chk("tie_b_result", {32'd0, rsp1_result}, 64'd12);
        cyc();

        // Back-pressure on rsp0 blocks req0 only; its result stays stable.
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 1'b0;
        #1;
        chk("bp_ready0_first", {63'd0, req0_ready}, 64'd1);
        cyc();
        cyc();
        exp_cnt0++;
        chk("bp_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        chk("bp_rsp0_result", {32'd0, rsp0_result}, 64'd101);
        chk("bp_ready0_blocked_idle", {63'd0, req0_ready}, 64'd0);
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_op = 1'b1;
        #1;
        chk("bp_ready1", {63'd0, req1_ready}, 64'd1);
        cyc();
        req1_valid = 1'b0;
        chk("bp_ready0_exec", {63'd0, req0_ready}, 64'd0);
        chk("bp_rsp0_hold1", {32'd0, rsp0_result}, 64'd101);
        cyc();
        exp_cnt1++;
        chk("bp_rsp1_result", {32'd0, rsp1_result}, 64'd5);
        chk("bp_ready0_still", {63'd0, req0_ready}, 64'd0);
        chk("bp_rsp0_valid_hold", {63'd0, rsp0_valid}, 64'd1);
        chk("bp_rsp0_hold2", {32'd0, rsp0_result}, 64'd101);
        rsp0_ready = 1'b1;
        cyc();
        chk("bp_rsp0_drained", {63'd0, rsp0_valid}, 64'd0);
        chk("bp_ready0_reaccept", {63'd0, req0_ready}, 64'd1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        exp_cnt0++;
        chk("bp_rsp0_second", {32'd0, rsp0_result}, 64'd101);
        cyc();
        chk("bp_cnt0", {62'd0, cnt0}, 64'(exp_cnt0 % 4));
        chk("bp_cnt1", {62'd0, cnt1}, 64'(exp_cnt1 % 4));

        // Reset during EXEC of req1 drops the operation.
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd1; req1_op = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("mr_ready1", {63'd0, req1_ready}, 64'd1);
        cyc();
        req1_valid = 1'b0;
        chk("mr_busy_before", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        chk("mr_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        chk("mr_busy", {63'd0, busy}, 64'd0);
        chk("mr_cnt", {60'd0, cnt1, cnt0}, 64'd0);
        cyc();
        chk("mr_rsp1_valid_late", {63'd0, rsp1_valid}, 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_ptr_ready0", {63'd0, req0_ready}, 64'd1);
        chk("mr_ptr_ready1", {63'd0, req1_ready}, 64'd0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        cyc();

        // Counter wraps at 2^CW.
        do_reset();
        chk("wrap_cnt0_init", {62'd0, cnt0}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            single_op(1'b0, 32'(i), 32'd1, 1'b0, 32'(i + 1), 1'b0);
            chk($sformatf("wrap_cnt0_%0d", i), {62'd0, cnt0}, 64'(wrap_exp[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
